// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back and a long-latency unit.
// Pipeline has priority; a starvation FSM forces a one-cycle stall so the long-latency result retires.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ip_wb_RegWrite,
    input  logic [ADDR_W-1:0] ip_wb_reg_addr,
    input  logic [DATA_W-1:0] ip_wb_data,
    input  logic              ip_lu_valid,
    input  logic [ADDR_W-1:0] ip_lu_reg_addr,
    input  logic [DATA_W-1:0] ip_lu_data,
    output logic              op_lu_ready,
    output logic              op_RegWrite,
    output logic [ADDR_W-1:0] op_write_reg_addr,
    output logic [DATA_W-1:0] op_write_data,
    output logic              op_stall,
    output logic              op_conflict_err
);

    typedef enum logic [1:0] {IDLE, WAIT, STALL, GRANT} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       pipe_live;
    logic       pipe_win;
    logic       lu_accept;
    logic       lu_blocked;

    always_comb begin
        pipe_live   = ip_wb_RegWrite && (ip_wb_reg_addr != '0);
        op_lu_ready = 1'b0;
        if (!reset)
            op_lu_ready = (state == GRANT) ? 1'b1 : !pipe_live;
        lu_accept  = ip_lu_valid && op_lu_ready;
        lu_blocked = ip_lu_valid && !op_lu_ready;
        pipe_win   = pipe_live && (state != GRANT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            op_RegWrite       <= 1'b0;
            op_write_reg_addr <= '0;
            op_write_data     <= '0;
            op_stall          <= 1'b0;
            op_conflict_err   <= 1'b0;
        end else begin
            op_RegWrite <= 1'b0;
            op_stall    <= 1'b0;

            // An accepted lu write to r0 is consumed silently; addr/data keep their last values.
            if (pipe_win) begin
                op_RegWrite       <= 1'b1;
                op_write_reg_addr <= ip_wb_reg_addr;
                op_write_data     <= ip_wb_data;
            end else if (lu_accept && (ip_lu_reg_addr != '0)) begin
                op_RegWrite       <= 1'b1;
                op_write_reg_addr <= ip_lu_reg_addr;
                op_write_data     <= ip_lu_data;
            end

            if ((state == GRANT) && pipe_live)
                op_conflict_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (lu_blocked) begin
                        state    <= WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                WAIT: begin
                    if (!ip_lu_valid || lu_accept) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == MAX_WAIT_C) begin
                        state    <= STALL;
                        op_stall <= 1'b1;
                    end else if (wait_cnt != 4'hF) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                STALL: begin
                    state    <= lu_accept ? IDLE : GRANT;
                    wait_cnt <= lu_accept ? '0 : wait_cnt;
                end
                GRANT: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
